// File: rtl/qf_io_ctrl_if.sv
// ---------------------------------------------------------------------------
// qf_io_ctrl_if
// Wishbone classic slave bundle for the management SoC port of qf_io_ctrl.
// Signal names keep the SoC-side wbs_* naming, so _i/_o are as seen by the
// slave.
//   wbs_cyc_i / wbs_stb_i / wbs_we_i : cycle, strobe, write enable
//   wbs_sel_i [3:0]                  : write byte lanes
//   wbs_adr_i [31:0]                 : byte address
//   wbs_dat_i [31:0]                 : write data
//   wbs_ack_o                        : single-cycle acknowledge
//   wbs_dat_o [31:0]                 : read data
// ---------------------------------------------------------------------------
interface qf_io_ctrl_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/qf_io_ctrl.sv
// ---------------------------------------------------------------------------
// qf_io_ctrl
// Pad ownership controller. Each user pad is either driven by the core
// (core_io_out / core_io_oeb) or by software override registers. Also
// provides a two-stage synchroniser for io_in readback and a software
// core-hold reset. Configuration writes are only accepted after the key
// sequence 0xA5, 0x5A has been written to KEY.
// Ports:
//   wb_clk_i      : only clock
//   wb_rst_i      : synchronous active-high reset
//   wbs           : Wishbone classic slave (qf_io_ctrl_if.slave)
//   core_io_out   : core pad output values
//   core_io_oeb   : core pad output enables (active-low)
//   io_in         : raw pad inputs
//   io_out        : pad outputs
//   io_oeb        : pad output enables (active-low)
//   core_rst_o    : reset to the core (wb_rst_i OR CTRL.HOLD)
// Register map (byte offsets): 0x00 CTRL, 0x04 KEY, 0x08/0C OWN,
// 0x10/14 OUT, 0x18/1C OEB, 0x20/24 IN.
// ---------------------------------------------------------------------------
module qf_io_ctrl #(
    parameter int          PADS      = 38,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    qf_io_ctrl_if.slave     wbs,
    input  logic [PADS-1:0] core_io_out,
    input  logic [PADS-1:0] core_io_oeb,
    input  logic [PADS-1:0] io_in,
    output logic [PADS-1:0] io_out,
    output logic [PADS-1:0] io_oeb,
    output logic            core_rst_o
);

    localparam int HI_W = PADS - 32;

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_ARMED    = 2'd1,
        ST_UNLOCKED = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_ack;
    logic [31:0]     r_dat;
    logic            r_hold;
    logic [PADS-1:0] r_sync1;
    logic [PADS-1:0] r_sync2;

    logic            w_hit;
    logic            w_req;
    logic            w_wr;
    logic            w_mapped;
    logic [3:0]      w_idx;
    logic            w_key_wr;
    logic            w_cfg_wr;
    logic [31:0]     w_rd_data;
    logic [PADS-1:0] w_own;
    logic [PADS-1:0] w_out;
    logic [PADS-1:0] w_oeb;
    logic            w_unused_adr;

    // Byte-lane merge of write data into an existing 32-bit register image.
    function automatic logic [31:0] f_be_merge(input logic [31:0] old_val,
                                               input logic [31:0] dat,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                res[8*b +: 8] = dat[8*b +: 8];
            end
        end
        return res;
    endfunction

    // -----------------------------------------------------------------------
    // Bus decode. The !r_ack term makes a held strobe ack every other cycle.
    // -----------------------------------------------------------------------
    assign w_hit        = (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign w_req        = wbs.wbs_cyc_i & wbs.wbs_stb_i & w_hit & ~r_ack;
    assign w_wr         = w_req & wbs.wbs_we_i;
    assign w_mapped     = (wbs.wbs_adr_i[7:6] == 2'b00);
    assign w_idx        = wbs.wbs_adr_i[5:2];
    assign w_key_wr     = w_mapped & (w_idx == 4'd1) & wbs.wbs_sel_i[0];
    // Config commit uses the state before this write's own FSM transition.
    assign w_cfg_wr     = w_wr & w_mapped & (r_state == ST_UNLOCKED);
    assign w_unused_adr = ^wbs.wbs_adr_i[1:0];

    // -----------------------------------------------------------------------
    // Override register banks: 0 = OWN, 1 = OUT, 2 = OEB.
    // Bank gi lives at index 2+2*gi (LO) and 3+2*gi (HI).
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_bank
            localparam logic [PADS-1:0] RST_VAL = (gi == 2) ? {PADS{1'b1}} : {PADS{1'b0}};
            logic [PADS-1:0] r_bank;
            logic [31:0]     w_lo_cur;
            logic [31:0]     w_hi_cur;
            logic [31:0]     w_lo_next;
            logic [31:0]     w_hi_next;

            assign w_lo_cur  = r_bank[31:0];
            // Unimplemented HI bits are zero-extended so they read as 0.
            assign w_hi_cur  = 32'(r_bank[PADS-1:32]);
            assign w_lo_next = f_be_merge(w_lo_cur, wbs.wbs_dat_i, wbs.wbs_sel_i);
            assign w_hi_next = f_be_merge(w_hi_cur, wbs.wbs_dat_i, wbs.wbs_sel_i);

            always_ff @(posedge wb_clk_i) begin
                if (wb_rst_i) begin
                    r_bank <= RST_VAL;
                end else if (w_cfg_wr && (w_idx == 4'(2 + 2*gi))) begin
                    r_bank[31:0] <= w_lo_next;
                end else if (w_cfg_wr && (w_idx == 4'(3 + 2*gi))) begin
                    r_bank[PADS-1:32] <= w_hi_next[HI_W-1:0];
                end
            end
        end
    endgenerate

    assign w_own = g_bank[0].r_bank;
    assign w_out = g_bank[1].r_bank;
    assign w_oeb = g_bank[2].r_bank;

    // -----------------------------------------------------------------------
    // Per-pad ownership mux
    // -----------------------------------------------------------------------
    generate
        for (gi = 0; gi < PADS; gi++) begin : g_pad
            assign io_out[gi] = w_own[gi] ? w_out[gi] : core_io_out[gi];
            assign io_oeb[gi] = w_own[gi] ? w_oeb[gi] : core_io_oeb[gi];
        end
    endgenerate

    assign core_rst_o = wb_rst_i | r_hold;

    // -----------------------------------------------------------------------
    // Unlock FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_LOCKED;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_wr) begin
            case (r_state)
                ST_LOCKED: begin
                    if (w_key_wr && (wbs.wbs_dat_i[7:0] == 8'hA5)) begin
                        w_state_next = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    // Any acked write other than the second key aborts.
                    if (w_key_wr && (wbs.wbs_dat_i[7:0] == 8'h5A)) begin
                        w_state_next = ST_UNLOCKED;
                    end else begin
                        w_state_next = ST_LOCKED;
                    end
                end
                ST_UNLOCKED: begin
                    if (w_key_wr && (wbs.wbs_dat_i[7:0] == 8'h00)) begin
                        w_state_next = ST_LOCKED;
                    end
                end
                default: w_state_next = ST_LOCKED;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // CTRL.HOLD and input synchroniser
    // -----------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_hold  <= 1'b0;
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= io_in;
            r_sync2 <= r_sync1;
            if (w_cfg_wr && (w_idx == 4'd0) && wbs.wbs_sel_i[0]) begin
                r_hold <= wbs.wbs_dat_i[0];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read mux (pre-commit values) and registered response
    // -----------------------------------------------------------------------
    always_comb begin
        w_rd_data = '0;
        if (w_mapped) begin
            case (w_idx)
                4'd0:    w_rd_data = {30'd0, (r_state != ST_UNLOCKED), r_hold};
                4'd1:    w_rd_data = {30'd0, r_state};
                4'd2:    w_rd_data = g_bank[0].w_lo_cur;
                4'd3:    w_rd_data = g_bank[0].w_hi_cur;
                4'd4:    w_rd_data = g_bank[1].w_lo_cur;
                4'd5:    w_rd_data = g_bank[1].w_hi_cur;
                4'd6:    w_rd_data = g_bank[2].w_lo_cur;
                4'd7:    w_rd_data = g_bank[2].w_hi_cur;
                4'd8:    w_rd_data = r_sync2[31:0];
                4'd9:    w_rd_data = 32'(r_sync2[PADS-1:32]);
                default: w_rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_req;
            r_dat <= (w_req && !wbs.wbs_we_i) ? w_rd_data : 32'd0;
        end
    end

    assign wbs.wbs_ack_o = r_ack;
    assign wbs.wbs_dat_o = r_dat;

endmodule

// File: tb/tb_qf_io_ctrl.sv
// ---------------------------------------------------------------------------
// tb_qf_io_ctrl
// Directed bench for qf_io_ctrl. Expected read data is queued when a read is
// issued and popped when the ack returns; pad and reset outputs are checked
// directly against bench-computed constants.
// ---------------------------------------------------------------------------
module tb_qf_io_ctrl;
    localparam int          PADS = 38;
    localparam logic [31:0] BASE = 32'h3000_0000;

    localparam logic [31:0] A_CTRL   = 32'h00;
    localparam logic [31:0] A_KEY    = 32'h04;
    localparam logic [31:0] A_OWN_LO = 32'h08;
    localparam logic [31:0] A_OWN_HI = 32'h0C;
    localparam logic [31:0] A_OUT_LO = 32'h10;
    localparam logic [31:0] A_OUT_HI = 32'h14;
    localparam logic [31:0] A_OEB_LO = 32'h18;
    localparam logic [31:0] A_OEB_HI = 32'h1C;
    localparam logic [31:0] A_IN_LO  = 32'h20;
    localparam logic [31:0] A_IN_HI  = 32'h24;

    logic            clk = 1'b0;
    logic            rst;
    logic [PADS-1:0] core_io_out;
    logic [PADS-1:0] core_io_oeb;
    logic [PADS-1:0] io_in;
    logic [PADS-1:0] io_out;
    logic [PADS-1:0] io_oeb;
    logic            core_rst_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    qf_io_ctrl_if wbif ();

    qf_io_ctrl #(
        .PADS      (PADS),
        .BASE_ADDR (BASE)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs         (wbif),
        .core_io_out (core_io_out),
        .core_io_oeb (core_io_oeb),
        .io_in       (io_in),
        .io_out      (io_out),
        .io_oeb      (io_oeb),
        .core_rst_o  (core_rst_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One Wishbone classic transfer; gives up after 8 cycles without ack.
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rd, output logic acked);
        wbif.wbs_cyc_i = 1'b1;
        wbif.wbs_stb_i = 1'b1;
        wbif.wbs_we_i  = we;
        wbif.wbs_adr_i = adr;
        wbif.wbs_dat_i = dat;
        wbif.wbs_sel_i = sel;
        acked = 1'b0;
        rd    = '0;
        for (int i = 0; i < 8 && !acked; i++) begin
            @(posedge clk);
            #1;
            if (wbif.wbs_ack_o) begin
                acked = 1'b1;
                rd    = wbif.wbs_dat_o;
            end
        end
        wbif.wbs_cyc_i = 1'b0;
        wbif.wbs_stb_i = 1'b0;
        wbif.wbs_we_i  = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] off, input logic [31:0] dat,
                            input logic [3:0] sel, input string tag);
        logic [31:0] rd;
        logic        acked;
        wb_xfer(1'b1, BASE + off, dat, sel, rd, acked);
        $display("[TB] write off=0x%02h dat=0x%08h sel=0x%h ack=%0b (%s)", off, dat, sel, acked, tag);
        check({tag, "_ack"}, 64'(acked), 64'd1);
    endtask

    task automatic wb_read(input logic [31:0] off, input logic [31:0] exp, input string tag);
        logic [31:0] rd;
        logic        acked;
        logic [31:0] e;
        string       t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        wb_xfer(1'b0, BASE + off, 32'd0, 4'h0, rd, acked);
        $display("[TB] read  off=0x%02h dat=0x%08h ack=%0b (%s)", off, rd, acked, tag);
        check({tag, "_ack"}, 64'(acked), 64'd1);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (acked) begin
            check(t, 64'(rd), 64'(e));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        acked;

        rst            = 1'b1;
        wbif.wbs_cyc_i = 1'b0;
        wbif.wbs_stb_i = 1'b0;
        wbif.wbs_we_i  = 1'b0;
        wbif.wbs_sel_i = 4'h0;
        wbif.wbs_adr_i = '0;
        wbif.wbs_dat_i = '0;
        core_io_out    = 38'h15_1234_5678;
        core_io_oeb    = 38'h0A_F0F0_0F0F;
        io_in          = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_core_rst", 64'(core_rst_o), 64'd1);
        check("rst_ack", 64'(wbif.wbs_ack_o), 64'd0);
        check("rst_dat", 64'(wbif.wbs_dat_o), 64'd0);
        check("rst_io_out", 64'(io_out), 64'(core_io_out));
        check("rst_io_oeb", 64'(io_oeb), 64'(core_io_oeb));
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("core_rst_released", 64'(core_rst_o), 64'd0);

        wb_read(A_CTRL,   32'h2,         "rd_ctrl");
        wb_read(A_KEY,    32'h0,         "rd_key");
        wb_read(A_OWN_LO, 32'h0,         "rd_own_lo");
        wb_read(A_OWN_HI, 32'h0,         "rd_own_hi");
        wb_read(A_OUT_LO, 32'h0,         "rd_out_lo");
        wb_read(A_OUT_HI, 32'h0,         "rd_out_hi");
        wb_read(A_OEB_LO, 32'hFFFF_FFFF, "rd_oeb_lo");
        wb_read(A_OEB_HI, 32'h0000_003F, "rd_oeb_hi");
        wb_read(A_IN_LO,  32'h0,         "rd_in_lo");

        // Locked writes are discarded
        wb_write(A_OWN_LO, 32'hFFFF_FFFF, 4'hF, "locked_own_wr");
        wb_read(A_OWN_LO, 32'h0, "locked_own_rd");
        check("locked_io_out", 64'(io_out), 64'(core_io_out));

        // Window miss gets no ack; unmapped offset acks and reads 0
        wb_xfer(1'b1, BASE + 32'h100, 32'hFFFF_FFFF, 4'hF, rd, acked);
        $display("[TB] write miss ack=%0b", acked);
        check("miss_noack", 64'(acked), 64'd0);
        wb_read(32'h40, 32'h0, "unmapped_rd");

        // Unlock
        wb_write(A_KEY, 32'hA5, 4'h1, "key_a5");
        wb_read(A_KEY, 32'h1, "key_armed");
        wb_write(A_KEY, 32'h5A, 4'h1, "key_5a");
        wb_read(A_KEY, 32'h2, "key_unlocked");
        wb_read(A_CTRL, 32'h0, "ctrl_unlocked");

        // Take pad 0 under software control
        wb_write(A_OWN_LO, 32'h1, 4'hF, "own0");
        wb_write(A_OUT_LO, 32'h1, 4'hF, "out0");
        check("pad0_out", 64'(io_out), 64'({core_io_out[37:1], 1'b1}));
        wb_write(A_OEB_LO, 32'h0, 4'hF, "oeb0");
        check("pad0_oeb", 64'(io_oeb), 64'({core_io_oeb[37:1], 1'b0}));
        check("pad0_out_hold", 64'(io_out), 64'({core_io_out[37:1], 1'b1}));

        // Byte lane 1 only
        wb_write(A_OUT_LO, 32'hFFFF_FFFF, 4'h2, "out_sel2");
        wb_read(A_OUT_LO, 32'h0000_FF01, "out_sel2_rd");

        // HI register: only 6 bits implemented
        wb_write(A_OWN_HI, 32'hFFFF_FFFF, 4'hF, "own_hi");
        wb_read(A_OWN_HI, 32'h3F, "own_hi_rd");
        check("own_hi_io_out", 64'(io_out), 64'({6'h00, core_io_out[31:1], 1'b1}));
        check("own_hi_io_oeb", 64'(io_oeb), 64'({6'h3F, core_io_oeb[31:1], 1'b0}));
        wb_write(A_OWN_HI, 32'h0, 4'hF, "own_hi_clr");
        check("own_hi_clr_io_out", 64'(io_out), 64'({core_io_out[37:1], 1'b1}));

        // Aborted unlock: A5, other write, 5A -> LOCKED, OUT_LO unchanged
        wb_write(A_KEY, 32'h00, 4'h1, "relock");
        wb_read(A_KEY, 32'h0, "relock_rd");
        wb_write(A_KEY, 32'hA5, 4'h1, "abort_a5");
        wb_write(A_OUT_LO, 32'h1234_5678, 4'hF, "abort_out");
        wb_write(A_KEY, 32'h5A, 4'h1, "abort_5a");
        wb_read(A_KEY, 32'h0, "abort_key_rd");
        wb_read(A_OUT_LO, 32'h0000_FF01, "abort_out_rd");

        // Input synchroniser latency
        io_in = 38'h2A_5A5A_5A5A;
        @(posedge clk);
        #1;
        wb_read(A_IN_LO, 32'h0, "in_lo_early");
        wb_read(A_IN_LO, 32'h5A5A_5A5A, "in_lo");
        wb_read(A_IN_HI, 32'h2A, "in_hi");

        // Core hold
        wb_write(A_KEY, 32'hA5, 4'h1, "hold_a5");
        wb_write(A_KEY, 32'h5A, 4'h1, "hold_5a");
        wb_write(A_CTRL, 32'h1, 4'h1, "hold_set");
        check("hold_core_rst", 64'(core_rst_o), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("hold_core_rst_stays", 64'(core_rst_o), 64'd1);
        wb_read(A_CTRL, 32'h1, "hold_ctrl_rd");
        wb_write(A_CTRL, 32'h0, 4'h1, "hold_clr");
        check("hold_core_rst_clr", 64'(core_rst_o), 64'd0);

        // Reset during a pending write
        wbif.wbs_cyc_i = 1'b1;
        wbif.wbs_stb_i = 1'b1;
        wbif.wbs_we_i  = 1'b1;
        wbif.wbs_adr_i = BASE + A_OEB_LO;
        wbif.wbs_dat_i = 32'h0;
        wbif.wbs_sel_i = 4'hF;
        rst            = 1'b1;
        @(posedge clk);
        #1;
        $display("[TB] write off=0x18 under reset ack=%0b", wbif.wbs_ack_o);
        check("rst_mid_noack", 64'(wbif.wbs_ack_o), 64'd0);
        wbif.wbs_cyc_i = 1'b0;
        wbif.wbs_stb_i = 1'b0;
        wbif.wbs_we_i  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wb_read(A_OEB_LO, 32'hFFFF_FFFF, "rst_mid_oeb_rd");
        wb_read(A_KEY, 32'h0, "rst_mid_key_rd");
        wb_read(A_OUT_LO, 32'h0, "rst_mid_out_rd");
        check("rst_mid_io_out", 64'(io_out), 64'(core_io_out));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
